// File: rtl/heap_pkg.sv
// rtl/heap_pkg.sv - opcodes and FSM state encoding shared by the heap command scheduler.
package heap_pkg;

  typedef enum logic [1:0] {
    OP_BUILD   = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_ILLEGAL = 2'b11
  } heap_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_RESPOND   = 2'b11
  } sched_state_e;

endpackage

// File: rtl/heap_cmd_fifo.sv
// rtl/heap_cmd_fifo.sv - synchronous command FIFO with full/empty flags and same-cycle read/write.
module heap_cmd_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/heap_cmd_scheduler.sv
// rtl/heap_cmd_scheduler.sv - buffers heap commands, issues them one at a time, returns in-order responses.
module heap_cmd_scheduler
  import heap_pkg::*;
#(
  parameter int KEY_W      = 32,
  parameter int N_W        = 10,
  parameter int CAP        = 1023,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [KEY_W-1:0] cmd_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [KEY_W-1:0] rsp_key,
  output logic             rsp_err,
  output logic             heap_start,
  output logic [1:0]       heap_instruction,
  output logic [KEY_W-1:0] heap_key,
  input  logic             heap_done,
  input  logic [KEY_W-1:0] heap_arr_out,
  input  logic [N_W-1:0]   heap_n,
  output logic             busy,
  output logic             timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  logic [1:0]       cur_op_q, cur_op_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic [KEY_W-1:0] rsp_key_q, rsp_key_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             fifo_full, fifo_empty, fifo_rd;
  logic [KEY_W+1:0] fifo_head;
  logic [1:0]       head_op;
  logic [KEY_W-1:0] head_key;
  logic             head_bad;

  heap_cmd_fifo #(.W(KEY_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (cmd_valid),
    .wr_data_i ({cmd_op, cmd_key}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign head_op  = fifo_head[KEY_W+1:KEY_W];
  assign head_key = fifo_head[KEY_W-1:0];
  // Commands the heap cannot legally execute are answered locally, never issued.
  assign head_bad = (head_op == OP_ILLEGAL) ||
                    (head_op == OP_PUSH && heap_n == N_W'(CAP)) ||
                    (head_op == OP_POP  && heap_n == '0);

  assign cmd_ready        = !fifo_full;
  assign heap_start       = (state_q == ST_ISSUE);
  assign heap_instruction = cur_op_q;
  assign heap_key         = cur_key_q;
  assign rsp_valid        = (state_q == ST_RESPOND);
  assign rsp_key          = rsp_key_q;
  assign rsp_err          = rsp_err_q;
  assign busy             = (state_q != ST_IDLE) || !fifo_empty;
  assign timeout_err      = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_op_q  <= '0;
      cur_key_q <= '0;
      rsp_key_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_op_q  <= cur_op_d;
      cur_key_q <= cur_key_d;
      rsp_key_q <= rsp_key_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_op_d  = cur_op_q;
    cur_key_d = cur_key_q;
    rsp_key_d = rsp_key_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    fifo_rd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          cur_op_d  = head_op;
          cur_key_d = head_key;
          if (head_bad) begin
            rsp_err_d = 1'b1;
            rsp_key_d = '0;
            state_d   = ST_RESPOND;
          end else begin
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (heap_done) begin
          rsp_err_d = 1'b0;
          rsp_key_d = (cur_op_q == OP_POP)  ? heap_arr_out :
                      (cur_op_q == OP_PUSH) ? cur_key_q : '0;
          state_d   = ST_RESPOND;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_err_d = 1'b1;
          rsp_key_d = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
